// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and derived sync windows shared by the
// VGA timing generator and its pixel divider.
package vga_timing_pkg;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  // Half-open window test used for both sync pulses.
  function automatic logic in_window(input logic [31:0] v,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster interface between the timing generator (master) and the display
// renderer (slave).
interface vga_timing_gen_if;

  logic [31:0] row;
  logic [31:0] col;
  logic        vnotactive;
  logic        hsync;
  logic        vsync;
  logic        pix_en;
  logic        sof;

  modport master (output row, col, vnotactive, hsync, vsync, pix_en, sof);
  modport slave  (input  row, col, vnotactive, hsync, vsync, pix_en, sof);

endinterface

// File: rtl/vga_timing_gen_pix_tick_gen.sv
// Pixel-rate divider: pix_en is a registered one-clock pulse whenever the
// divider sits at CLK_DIV-1; forced low while RST is asserted.
module pix_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic pix_en
);

  localparam logic [31:0] DIV_LAST = 32'(CLK_DIV - 1);

  logic [31:0] r_div;
  logic [31:0] w_div_next;
  logic        r_pix_en;

  assign w_div_next = (r_div == DIV_LAST) ? 32'd0 : r_div + 32'd1;

  // pix_en is decoded from the next divider value so it is high exactly
  // while r_div == CLK_DIV-1.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_div    <= 32'd0;
      r_pix_en <= 1'b0;
    end else begin
      r_div    <= w_div_next;
      r_pix_en <= (w_div_next == DIV_LAST);
    end
  end

  assign pix_en = r_pix_en;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, sync/blanking decode and start-of-frame pulse for the VGA
// output. Define VGA_SYNC_DELAY_EN to delay hsync/vsync by one CLK.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             CLK,
  input  logic             RST,
  vga_timing_gen_if.master vga
);

  localparam logic [31:0] H_LAST  = 32'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [31:0] V_LAST  = 32'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [31:0] H_ACT   = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT   = 32'(V_ACTIVE);
  localparam logic [31:0] H_SS    = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] H_SE    = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] V_SS    = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] V_SE    = 32'(V_ACTIVE + V_FP + V_SYNC);

  logic        w_pix_en;
  logic [31:0] r_row;
  logic [31:0] r_col;
  logic [31:0] w_row_next;
  logic [31:0] w_col_next;
  logic        w_frame_wrap;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_vnotactive;
  logic        r_sof;

  pix_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick (
    .CLK    (CLK),
    .RST    (RST),
    .pix_en (w_pix_en)
  );

  always_comb begin
    w_row_next = r_row;
    w_col_next = r_col;
    if (w_pix_en) begin
      if (r_col == H_LAST) begin
        w_col_next = 32'd0;
        w_row_next = (r_row == V_LAST) ? 32'd0 : r_row + 32'd1;
      end else begin
        w_col_next = r_col + 32'd1;
      end
    end
  end

  assign w_frame_wrap = w_pix_en && (r_col == H_LAST) && (r_row == V_LAST);

  // Decode from the next counter values so the registered flags line up
  // with the row/col presented in the same cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_row        <= 32'd0;
      r_col        <= 32'd0;
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_vnotactive <= 1'b0;
      r_sof        <= 1'b0;
    end else begin
      r_row        <= w_row_next;
      r_col        <= w_col_next;
      r_hsync      <= !in_window(w_col_next, H_SS, H_SE);
      r_vsync      <= !in_window(w_row_next, V_SS, V_SE);
      r_vnotactive <= (w_col_next >= H_ACT) || (w_row_next >= V_ACT);
      r_sof        <= w_frame_wrap;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic r_hsync_dly;
  logic r_vsync_dly;

  // Extra stage keeps sync aligned with the renderer's registered RGB.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_hsync_dly <= 1'b1;
      r_vsync_dly <= 1'b1;
    end else begin
      r_hsync_dly <= r_hsync;
      r_vsync_dly <= r_vsync;
    end
  end

  assign vga.hsync = r_hsync_dly;
  assign vga.vsync = r_vsync_dly;
`else
  assign vga.hsync = r_hsync;
  assign vga.vsync = r_vsync;
`endif

  assign vga.row        = r_row;
  assign vga.col        = r_col;
  assign vga.vnotactive = r_vnotactive;
  assign vga.pix_en     = w_pix_en;
  assign vga.sof        = r_sof;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480 tic-tac-toe display. It derives a pixel-rate enable from the system clock and runs horizontal/vertical counters. It drives the `row`, `col` and `vnotactive` inputs of the display block, plus `hsync`/`vsync` to the VGA connector. It is the producer end of the row/col/blanking interface that the display renderer consumes.

## Interface
Parameters:
- `CLK_DIV`, 2: system clocks per pixel (50 MHz to 25 MHz); legal range ≥1.
- `H_ACTIVE`, 640: visible columns.
- `H_FP`, 16: horizontal front porch, pixels.
- `H_SYNC`, 96: hsync pulse width, pixels.
- `H_BP`, 48: horizontal back porch, pixels.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch, lines.
- `V_SYNC`, 2: vsync pulse width, lines.
- `V_BP`, 33: vertical back porch, lines.

Ports:
- `CLK`, input, 1: system clock.
- `RST`, input, 1: reset. Synchronous, active-low.
- `row`, output, 32: current line, 0..V_TOTAL-1 (V_TOTAL = 525 by default).
- `col`, output, 32: current pixel in the line, 0..H_TOTAL-1 (H_TOTAL = 800 by default).
- `vnotactive`, output, 1: high when (row, col) is outside the visible area.
- `hsync`, output, 1: horizontal sync, active-low.
- `vsync`, output, 1: vertical sync, active-low.
- `pix_en`, output, 1: one-CLK pulse per pixel period.
- `sof`, output, 1: one-CLK pulse when the raster wraps to (0,0).

## Operation
- Divider counter `div` runs 0..CLK_DIV-1.
  - `pix_en` is high in the cycle where `div == CLK_DIV-1`.
  - With CLK_DIV=1, `pix_en` is constantly high after reset.
- On each CLK edge where `pix_en` is high, the raster advances:
  - `col` increments by 1.
  - At `col == H_TOTAL-1`, `col` wraps to 0 and `row` increments.
  - At `row == V_TOTAL-1` on a line wrap, `row` wraps to 0.
- `hsync`, `vsync` and `vnotactive` are registered. They are computed from the next counter values, so in any cycle they describe the `row`/`col` currently on the outputs.
  - `hsync` = 0 iff `H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC`, i.e. 656..751 by default.
  - `vsync` = 0 iff `V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC`, i.e. 490..491 by default.
  - `vnotactive` = 1 iff `col >= H_ACTIVE` or `row >= V_ACTIVE`.
- `sof` is high for exactly one CLK, in the cycle `row`/`col` first read (0,0) after a frame wrap. It is not asserted on reset exit.
- Reset values, applied on any CLK edge with `RST` = 0:
  - `div` = 0, `row` = 0, `col` = 0.
  - `hsync` = 1, `vsync` = 1.
  - `vnotactive` = 0, `pix_en` = 0, `sof` = 0.
- Reset mid-frame forces the reset values on the next edge. The partial line/frame is discarded. There is no glitch pulse on `sof`.
- Width rule: counters are held in 32-bit registers; bits above the value range are always 0.

## Timing
- Default line is 800 pixels = 1600 CLK. Default frame is 525 lines = 840 000 CLK.
- After `RST` deasserts at edge E:
  - the first `pix_en` is at cycle E+CLK_DIV-1;
  - `col` becomes 1 at edge E+CLK_DIV.
- `row`/`col` change only on the edge following a `pix_en` cycle. They are stable for CLK_DIV cycles.
- `sof` coincides with the `pix_en` period in which `col` = 0 and `row` = 0; it lasts one CLK, not one pixel.
- Without the macro below, the sync outputs have zero latency relative to `row`/`col`.

## Configuration
- `VGA_SYNC_DELAY_EN` defined:
  - `hsync` and `vsync` pass through one extra CLK register stage, which matches the display block's registered RGB output. Reset value of this stage is 1.
  - `row`, `col`, `vnotactive`, `pix_en` and `sof` are unchanged.
- Undefined: `hsync`/`vsync` are aligned with `row`/`col` exactly as described in Operation.

## Structure
- Shared package `vga_timing_pkg`:
  - default timing constants (H_*/V_* and CLK_DIV);
  - derived H_TOTAL, V_TOTAL and sync start/end localparams.
- Sub-module `pix_tick_gen`: parameterized CLK_DIV divider producing `pix_en`, with the same synchronous active-low reset.
- Top level holds the raster counters, the decode logic and the optional sync delay stage.

## Test plan
- Reset exit, defaults: hold `RST`=0 for 3 cycles then release. `pix_en` is first high at the 2nd cycle after release. `col` reads 1 one cycle later. `hsync`=`vsync`=1 and `vnotactive`=0 throughout.
- Line timing: count CLK between `col`=655→656 and `col`=751→752. `hsync` is low for exactly 192 CLK. `vnotactive` goes 1 at `col`=640 and returns to 0 at `col`=0 on row 1.
- Frame timing: run one frame.
  - `vsync` is low only for rows 490 and 491 (1600 CLK each).
  - `vnotactive`=1 on every pixel of rows 480..524.
  - `sof` pulses once at 840 000 CLK after the first (0,0).
- Wrap: at (row 524, col 799) the next pixel is (0,0), with exactly one `sof` pulse; `row` never reads 525.
- Mid-frame reset: assert `RST`=0 for 1 cycle at row 300, col 400. Next edge gives (0,0), `hsync`=`vsync`=1, no `sof`. Counting resumes normally.
- Configuration and CLK_DIV=1:
  - With `VGA_SYNC_DELAY_EN`, `hsync` falls exactly one CLK after `col` reads 656.
  - With CLK_DIV=1, `pix_en` stays 1 and `col` advances every CLK.
